sram_pattern_checker: RTL and testbench
=======================================

# sram_pattern_checker

Read-back verifier for the SRAM test path: walks an address range, issues read requests to the SRAM controller, and compares every returned word against the expected word for a selected test pattern. It uses the same 3-bit pattern encoding as the test pattern sequencer, so the test top can run write pass, read/check pass, and advance pattern. It reports pass/fail, a saturating error count, and the first mismatch.

## Interface
- DATA_BITS, 16, data word width; must be even
- ADDR_BITS, 20, address width; range checked is 0 .. 2^ADDR_BITS-1
- ERR_BITS, 16, width of error counter
- MAX_OUTSTANDING, 4, max reads accepted but not yet returned (power of 2, ≥1)

- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: begin a check pass
- pattern_sel  input  3  pattern code, sampled on start
- custom  input  DATA_BITS  custom pattern word, sampled on start
- rd_valid  output  1  read request valid
- rd_ready  input  1  controller accepts request when rd_valid & rd_ready
- rd_addr  output  ADDR_BITS  request address
- rd_data_valid  input  1  one returned word this cycle; returns are in request order
- rd_data  input  DATA_BITS  returned word
- busy  output  1  pass in progress
- done  output  1  pass complete; held until next start or reset
- pass  output  1  valid when done: 1 iff err_count == 0
- err_count  output  ERR_BITS  mismatches this pass, saturating
- first_err_addr  output  ADDR_BITS  address of first mismatch
- first_err_data  output  DATA_BITS  data read at first mismatch

## Operation
- Expected word by pattern_sel: 0 all zeros; 1 all ones; 2 {DATA_BITS/2{2'b10}}; 3 {DATA_BITS/2{2'b01}}; 4 all-ones >> DATA_BITS/2 (low half ones); 5 all zeros; 6 latched custom; 7 all zeros.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE/DONE --start--> READ. On entry: req_addr = 0, cmp_addr = 0, outstanding = 0, err_count = 0, first_err_* = 0, done = 0, pass = 0. Latch pattern_sel and custom.
  - READ: rd_valid = 1 when outstanding < MAX_OUTSTANDING (after counting a same-cycle return). rd_addr = req_addr. Each handshake increments req_addr. Accepting address 2^ADDR_BITS-1 moves to DRAIN. req_addr does not wrap.
  - DRAIN: rd_valid = 0. Move to DONE once the return for the last address has been compared.
  - DONE: done = 1, pass = (err_count == 0).
- Compare (READ/DRAIN): on each rd_data_valid, compare rd_data to the expected word at cmp_addr, then cmp_addr++.
  - On mismatch: err_count++, saturating at all ones.
  - If it is the first mismatch, capture cmp_addr and rd_data.
- outstanding: +1 on handshake, −1 on rd_data_valid; both in one cycle leaves it unchanged.
- rd_data_valid in IDLE/DONE is ignored.
- start while busy is ignored.
- busy = state is READ or DRAIN.

## Timing
- Reset (async assert, sync release): state IDLE; rd_valid 0, rd_addr 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0, first_err_data 0.
- Reset mid-pass aborts immediately. rd_valid drops with reset asserted; pending returns after release are ignored.
- start at cycle N: busy = 1 and rd_valid = 1 at N+1.
- All outputs are registered.
- Compare result updates err_count/first_err_* the cycle after rd_data_valid.
- done/pass assert the cycle after the err_count update for the final word. Minimum pass length is 2^ADDR_BITS + 2 cycles after start with zero-latency returns.
- rd_addr/rd_valid are stable while rd_valid & !rd_ready.
- Throughput: one request per cycle while rd_ready = 1 and outstanding limit is not reached.

## Test plan
- Config for all scenarios: ADDR_BITS=4, DATA_BITS=16, ERR_BITS=4.
- pattern_sel=1, model returns 16'hFFFF for all addresses with 2-cycle latency → 16 requests, addresses 0..15; done=1, pass=1, err_count=0; no more than 4 outstanding at any time.
- pattern_sel=2, model corrupts address 5 to 16'hAAAB → err_count=1, first_err_addr=5, first_err_data=16'hAAAB, pass=0.
- pattern_sel=6, custom=16'h1234, model returns 0 everywhere → err_count saturates at 4'hF, first_err_addr=0, first_err_data=0.
- pattern_sel=4, rd_ready toggled randomly, latency 0–3 → rd_addr held while stalled, sequential addresses, done with pass=1 and expected word 16'h00FF.
- Reset asserted at the 8th request → outputs cleared asynchronously. A new start then completes a full pass with err_count=0. A second start pulse during the pass has no effect.

Source files
------------

// File: rtl/sram_pattern_checker_if.sv
// Read-request bus between the pattern checker (master) and the SRAM controller (slave).
interface sram_pattern_checker_if #(
   parameter int DATA_BITS = 16,
   parameter int ADDR_BITS = 20
);
   logic                 rd_valid;
   logic                 rd_ready;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 rd_data_valid;
   logic [DATA_BITS-1:0] rd_data;

   modport master (
      output rd_valid, rd_addr,
      input  rd_ready, rd_data_valid, rd_data
   );

   modport slave (
      input  rd_valid, rd_addr,
      output rd_ready, rd_data_valid, rd_data
   );
endinterface

// File: rtl/sram_pattern_checker.sv
// Read-back verifier: sweeps the full address range, compares in-order returns against
// the selected test pattern and reports pass/fail, a saturating error count and the first miss.
module sram_pattern_checker #(
   parameter int DATA_BITS       = 16,
   parameter int ADDR_BITS       = 20,
   parameter int ERR_BITS        = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           pattern_sel,
   input  logic [DATA_BITS-1:0] custom,
   sram_pattern_checker_if.master rd,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_BITS-1:0]  err_count,
   output logic [ADDR_BITS-1:0] first_err_addr,
   output logic [DATA_BITS-1:0] first_err_data
);

   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   function automatic logic [DATA_BITS-1:0] expected_word(input logic [2:0]           sel,
                                                          input logic [DATA_BITS-1:0] cw);
      logic [DATA_BITS-1:0] ones;
      logic [DATA_BITS-1:0] w;
      ones = '1;
      w    = '0;
      case (sel)
         3'd1:    w = ones;
         3'd2:    w = {(DATA_BITS/2){2'b10}};
         3'd3:    w = {(DATA_BITS/2){2'b01}};
         3'd4:    w = ones >> (DATA_BITS/2);
         3'd6:    w = cw;
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic logic [ERR_BITS-1:0] sat_inc(input logic [ERR_BITS-1:0] v);
      return (v == '1) ? v : v + ERR_BITS'(1);
   endfunction

   logic [1:0]           state;
   logic [DATA_BITS-1:0] exp_word;
   logic [ADDR_BITS-1:0] cmp_addr;
   logic [OW-1:0]        outstanding;
   logic                 cmp_all;

   logic                 hs;
   logic                 ret;
   logic                 last_req;
   logic                 last_cmp;
   logic                 mismatch;
   logic [OW-1:0]        out_next;
   logic                 room_next;

   // Returns only count while a pass is live and words remain to be compared.
   assign hs        = rd.rd_valid & rd.rd_ready;
   assign ret       = rd.rd_data_valid & busy & ~cmp_all;
   assign last_req  = (rd.rd_addr == '1);
   assign last_cmp  = (cmp_addr == '1);
   assign mismatch  = (rd.rd_data != exp_word);
   assign out_next  = outstanding + OW'(hs) - OW'(ret);
   assign room_next = (out_next < OW'(MAX_OUTSTANDING));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rd.rd_valid    <= 1'b0;
         rd.rd_addr     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         exp_word       <= '0;
         cmp_addr       <= '0;
         outstanding    <= '0;
         cmp_all        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= READ;
                  rd.rd_valid    <= 1'b1;
                  rd.rd_addr     <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  first_err_data <= '0;
                  exp_word       <= expected_word(pattern_sel, custom);
                  cmp_addr       <= '0;
                  outstanding    <= '0;
                  cmp_all        <= 1'b0;
               end
            end
            READ: begin
               outstanding <= out_next;
               if (hs && last_req) begin
                  state       <= DRAIN;
                  rd.rd_valid <= 1'b0;
               end else begin
                  if (hs) rd.rd_addr <= rd.rd_addr + ADDR_BITS'(1);
                  rd.rd_valid <= room_next;
               end
            end
            default: begin
               outstanding <= out_next;
               // err_count already holds the final word's result here, so done lags it by one cycle.
               if (cmp_all) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
               end
            end
         endcase

         if (ret) begin
            if (last_cmp) cmp_all  <= 1'b1;
            else          cmp_addr <= cmp_addr + ADDR_BITS'(1);
            if (mismatch) begin
               err_count <= sat_inc(err_count);
               if (err_count == '0) begin
                  first_err_addr <= cmp_addr;
                  first_err_data <= rd.rd_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_pattern_checker.sv
// Randomized scoreboard bench for sram_pattern_checker with an in-order SRAM responder model.
module tb_sram_pattern_checker;

   localparam int DB = 16;
   localparam int AB = 4;
   localparam int EB = 4;
   localparam int MO = 4;
   localparam int NWORDS = 1 << AB;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    pattern_sel = '0;
   logic [DB-1:0] custom = '0;
   logic          busy;
   logic          done;
   logic          pass;
   logic [EB-1:0] err_count;
   logic [AB-1:0] first_err_addr;
   logic [DB-1:0] first_err_data;

   sram_pattern_checker_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) rd_bus ();

   sram_pattern_checker #(
      .DATA_BITS(DB), .ADDR_BITS(AB), .ERR_BITS(EB), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .pattern_sel(pattern_sel),
      .custom(custom),
      .rd(rd_bus),
      .busy(busy),
      .done(done),
      .pass(pass),
      .err_count(err_count),
      .first_err_addr(first_err_addr),
      .first_err_data(first_err_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AB-1:0] addr;
      int            due;
   } pend_t;

   typedef struct {
      logic [EB-1:0] errs;
      logic [AB-1:0] faddr;
      logic [DB-1:0] fdata;
      logic          ok;
   } res_t;

   pend_t         pq[$];
   logic [AB-1:0] addr_q[$];
   res_t          res_q[$];
   logic [DB-1:0] mem [NWORDS];

   int vectors = 0;
   int misses = 0;
   int hs_count = 0;
   int cyc = 0;
   bit stall_en = 1'b0;
   int lat_lo = 1;
   int lat_hi = 1;

   int            outst;
   bit            prev_stall;
   bit            prev_done;
   logic [AB-1:0] prev_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misses++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DB-1:0] pat_word(input logic [2:0] sel, input logic [DB-1:0] cw);
      case (sel)
         3'd1:    return 16'hFFFF;
         3'd2:    return 16'hAAAA;
         3'd3:    return 16'h5555;
         3'd4:    return 16'h00FF;
         3'd6:    return cw;
         default: return 16'h0000;
      endcase
   endfunction

   // Reference: every address in order, errors counted over the memory image, capped at all ones.
   task automatic queue_pass(input logic [2:0] sel, input logic [DB-1:0] cw);
      logic [DB-1:0] w;
      res_t          r;
      int            n;
      w = pat_word(sel, cw);
      n = 0;
      r.faddr = '0;
      r.fdata = '0;
      for (int a = 0; a < NWORDS; a++) begin
         addr_q.push_back(AB'(a));
         if (mem[a] != w) begin
            if (n == 0) begin
               r.faddr = AB'(a);
               r.fdata = mem[a];
            end
            n++;
         end
      end
      r.errs = EB'((n > 15) ? 15 : n);
      r.ok   = (n == 0);
      res_q.push_back(r);
   endtask

   task automatic pulse_start(input logic [2:0] sel, input logic [DB-1:0] cw);
      @(posedge clk); #1;
      start = 1'b1; pattern_sel = sel; custom = cw;
      @(posedge clk); #1;
      start = 1'b0; pattern_sel = 3'($urandom); custom = 16'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
      repeat (2) @(posedge clk);
      chk("result_consumed", 32'(res_q.size()), 32'd0);
      chk("addr_consumed", 32'(addr_q.size()), 32'd0);
      addr_q.delete();
      res_q.delete();
   endtask

   task automatic run_pass(input logic [2:0] sel, input logic [DB-1:0] cw, input bit dbl);
      queue_pass(sel, cw);
      pulse_start(sel, cw);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_rd_valid", 32'(rd_bus.rd_valid), 32'd1);
      chk("start_done_clear", 32'(done), 32'd0);
      if (dbl) begin
         repeat (4) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      wait_done();
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_rd_valid"}, 32'(rd_bus.rd_valid), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_bus.rd_addr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
      chk({tag, "_first_addr"}, 32'(first_err_addr), 32'd0);
      chk({tag, "_first_data"}, 32'(first_err_data), 32'd0);
   endtask

   // Responder: in-order returns, each due 1+lat cycles after its handshake.
   initial begin
      pend_t e;
      rd_bus.rd_ready      = 1'b0;
      rd_bus.rd_data_valid = 1'b0;
      rd_bus.rd_data       = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         rd_bus.rd_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (pq.size() > 0 && pq[0].due <= cyc) begin
            rd_bus.rd_data_valid = 1'b1;
            rd_bus.rd_data       = mem[pq[0].addr];
            void'(pq.pop_front());
         end else begin
            rd_bus.rd_data_valid = 1'b0;
            rd_bus.rd_data       = 16'($urandom);
         end
         @(negedge clk);
         if (reset && rd_bus.rd_valid && rd_bus.rd_ready) begin
            e.addr = rd_bus.rd_addr;
            e.due  = cyc + 1 + int'($urandom_range(lat_lo, lat_hi));
            pq.push_back(e);
         end
      end
   end

   // Monitor: request order, stall hold, outstanding bound, end-of-pass results.
   initial begin
      res_t r;
      bit   hs;
      outst = 0; prev_stall = 1'b0; prev_done = 1'b0; prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            outst = 0; prev_stall = 1'b0; prev_done = 1'b0;
            continue;
         end
         hs = rd_bus.rd_valid && rd_bus.rd_ready;
         if (prev_stall) begin
            chk("stall_valid_held", 32'(rd_bus.rd_valid), 32'd1);
            chk("stall_addr_held", 32'(rd_bus.rd_addr), 32'(prev_addr));
         end
         if (busy) begin
            if (hs) outst++;
            if (rd_bus.rd_data_valid) outst--;
         end
         if (hs) begin
            hs_count++;
            if (addr_q.size() == 0) begin
               vectors++;
               misses++;
               $display("FAIL spurious_req: got request addr %0h, expected none", rd_bus.rd_addr);
            end else begin
               chk("req_addr", 32'(rd_bus.rd_addr), 32'(addr_q.pop_front()));
            end
            chk("outstanding_le_max", 32'(outst <= MO), 32'd1);
         end
         prev_stall = rd_bus.rd_valid && !rd_bus.rd_ready;
         prev_addr  = rd_bus.rd_addr;
         if (done && !prev_done) begin
            if (res_q.size() == 0) begin
               vectors++;
               misses++;
               $display("FAIL spurious_done: got done=1, expected no pass to finish");
            end else begin
               r = res_q.pop_front();
               chk("err_count", 32'(err_count), 32'(r.errs));
               chk("first_err_addr", 32'(first_err_addr), 32'(r.faddr));
               chk("first_err_data", 32'(first_err_data), 32'(r.fdata));
               chk("pass", 32'(pass), 32'(r.ok));
            end
         end
         prev_done = done;
      end
   end

   initial begin
      logic [2:0]    sel;
      logic [DB-1:0] cw;
      logic [DB-1:0] w;
      int            n;

      repeat (3) @(posedge clk);
      #1 check_cleared("reset");
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // All ones, fixed two-cycle return latency.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'hFFFF;
      stall_en = 1'b0; lat_lo = 1; lat_hi = 1;
      run_pass(3'd1, 16'h0000, 1'b0);

      // Alternating pattern with a single corrupted word.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'hAAAA;
      mem[5] = 16'hAAAB;
      lat_lo = 0; lat_hi = 3;
      run_pass(3'd2, 16'h0000, 1'b0);

      // Custom word against an all-zero memory: counter saturates.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'h0000;
      run_pass(3'd6, 16'h1234, 1'b0);

      // Low-half ones with random back-pressure.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'h00FF;
      stall_en = 1'b1;
      run_pass(3'd4, 16'h0000, 1'b0);

      // Abort on the 8th request; memory mismatches so stray returns would show up.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'h0000;
      stall_en = 1'b0; lat_lo = 3; lat_hi = 3;
      queue_pass(3'd3, 16'h0000);
      hs_count = 0;
      pulse_start(3'd3, 16'h0000);
      n = 0;
      while (hs_count < 8 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("abort_reached_8", 32'(hs_count >= 8), 32'd1);
      #3 reset = 1'b0;
      #1 check_cleared("abort");
      addr_q.delete();
      res_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("post_abort_err_count", 32'(err_count), 32'd0);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);

      // Full pass after the abort, with a start pulse landing mid-pass.
      for (int a = 0; a < NWORDS; a++) mem[a] = 16'h5555;
      lat_lo = 0; lat_hi = 2;
      run_pass(3'd3, 16'h0000, 1'b1);

      // Every pattern code once, random sparse corruption and random timing.
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         cw  = 16'($urandom);
         w   = pat_word(sel, cw);
         for (int a = 0; a < NWORDS; a++)
            mem[a] = ($urandom_range(0, 4) == 0) ? (w ^ (16'h1 << $urandom_range(0, 15))) : w;
         stall_en = ($urandom_range(0, 1) == 1);
         lat_lo   = 0;
         lat_hi   = int'($urandom_range(0, 3));
         run_pass(sel, cw, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
